// File: rtl/capture_pkg.sv
// Shared types and constants for the capture-path run-length compressor.
package capture_pkg;

    // Default widths of the production capture path
    localparam int CAP_DATA_W = 256;
    localparam int CAP_CNT_W  = 64;

    // Token kind carried in the is_run bit
    localparam logic TOK_LITERAL = 1'b0;
    localparam logic TOK_RUN     = 1'b1;

    // Token layout as seen by the DRAM write stage at default width
    typedef struct packed {
        logic                  is_run;
        logic [CAP_DATA_W-1:0] data;
    } cap_token_t;

endpackage

// File: rtl/capture_token_fifo.sv
// Small token buffer: two ordered write ports per cycle, one read port,
// head-of-queue presented directly from storage, free-entry count exported.
module capture_token_fifo #(
    parameter  int TOK_W = 257,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  logic             push1,
    input  logic [TOK_W-1:0] wdata0,
    input  logic [TOK_W-1:0] wdata1,
    input  logic             pop,
    output logic             rvalid,
    output logic [TOK_W-1:0] rdata,
    output logic [LVL_W-1:0] free
);

    logic [TOK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_ptr_nxt = ptr_inc(wr_ptr);

    // Token storage; push1 always lands in the slot after push0
    // NOTE: storage is deliberately not reset; count defines what is valid and
    // the read port is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]     <= wdata0;
        if (push1) mem[wr_ptr_nxt] <= wdata1;
    end

    // Pointer and occupancy tracking
    // NOTE: non-blocking assignments so every update in this block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push0 && push1) wr_ptr <= ptr_inc(wr_ptr_nxt);
            else if (push0)     wr_ptr <= wr_ptr_nxt;
            if (pop)            rd_ptr <= ptr_inc(rd_ptr);
            count <= count + LVL_W'(push0) + LVL_W'(push1) - LVL_W'(pop);
        end
    end

    assign rvalid = (count != '0);
    assign rdata  = rvalid ? mem[rd_ptr] : '0;
    assign free   = LVL_W'(DEPTH) - count;

endmodule

// File: rtl/capture_rle_compressor.sv
// Run-length compressor for the capture path: first sample of a value goes out
// as a LITERAL, following identical samples are counted into RUN tokens.
module capture_rle_compressor
    import capture_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W,
    parameter int CNT_W  = CAP_CNT_W,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_rle,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_run,
    output logic [DATA_W-1:0] out_data,
    output logic              flush_done,
    output logic [CNT_W-1:0]  stat_in,
    output logic [CNT_W-1:0]  stat_out
);

    localparam int              TOK_W    = DATA_W + 1;
    localparam int              LVL_W    = $clog2(FIFO_D + 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = '1;
    localparam logic [CNT_W-1:0] RUN_LAST = RUN_MAX - CNT_W'(1);

    logic [DATA_W-1:0] held;
    logic [CNT_W-1:0]  run_cnt;
    logic              have_prev;
    logic              flush_pend;

    logic [LVL_W-1:0]  free_cnt;
    logic              beat;
    logic              match;
    logic              flush_apply;
    logic              push0;
    logic              push1;
    logic [TOK_W-1:0]  tok0;
    logic [TOK_W-1:0]  tok1;
    logic [TOK_W-1:0]  head;
    logic              pop;

    // Room for a RUN+LITERAL pair is required before any sample is taken,
    // so a beat can never overflow the buffer.
    assign in_ready    = !rst && !flush && !flush_pend && (free_cnt >= LVL_W'(2));
    assign beat        = in_valid && in_ready;
    assign match       = en_rle && have_prev && (in_data == held);
    assign flush_apply = !rst && (flush || flush_pend) && (free_cnt != '0);

    // Token generation for the current cycle; RUN always precedes LITERAL
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        push0 = 1'b0;
        push1 = 1'b0;
        tok0  = {TOK_RUN, DATA_W'(run_cnt)};
        tok1  = {TOK_LITERAL, in_data};
        if (flush_apply) begin
            push0 = (run_cnt != '0);
        end else if (beat) begin
            if (match) begin
                if (run_cnt == RUN_LAST) begin
                    push0 = 1'b1;
                    tok0  = {TOK_RUN, DATA_W'(RUN_MAX)};
                end
            end else if (run_cnt != '0) begin
                push0 = 1'b1;
                push1 = 1'b1;
            end else begin
                push0 = 1'b1;
                tok0  = {TOK_LITERAL, in_data};
            end
        end
    end

    // Compressor state: held sample, open run length, flush tracking, statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            held       <= '0;
            run_cnt    <= '0;
            have_prev  <= 1'b0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            stat_in    <= '0;
            stat_out   <= '0;
        end else begin
            flush_done <= flush_apply;
            stat_out   <= stat_out + CNT_W'(push0) + CNT_W'(push1);
            if (flush_apply) begin
                run_cnt    <= '0;
                have_prev  <= 1'b0;
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (beat) begin
                stat_in <= stat_in + CNT_W'(1);
                if (match) begin
                    run_cnt <= (run_cnt == RUN_LAST) ? '0 : run_cnt + CNT_W'(1);
                end else begin
                    held      <= in_data;
                    run_cnt   <= '0;
                    have_prev <= 1'b1;
                end
            end
        end
    end

    assign pop = out_valid && out_ready;

    capture_token_fifo #(
        .TOK_W (TOK_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push0  (push0),
        .push1  (push1),
        .wdata0 (tok0),
        .wdata1 (tok1),
        .pop    (pop),
        .rvalid (out_valid),
        .rdata  (head),
        .free   (free_cnt)
    );

    assign {out_is_run, out_data} = head;

endmodule

// File: tb/tb_capture_rle_compressor.sv
// Directed bench for capture_rle_compressor at DATA_W=8, CNT_W=4, FIFO_D=2.
module tb_capture_rle_compressor;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int FIFO_D = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en_rle = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_is_run;
    logic [DATA_W-1:0] out_data;
    logic              flush_done;
    logic [CNT_W-1:0]  stat_in;
    logic [CNT_W-1:0]  stat_out;

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] tok_q [$];

    always #5 clk = ~clk;

    capture_rle_compressor #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .FIFO_D (FIFO_D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_rle     (en_rle),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_is_run (out_is_run),
        .out_data   (out_data),
        .flush_done (flush_done),
        .stat_in    (stat_in),
        .stat_out   (stat_out)
    );

    // Record each token the cycle before it is consumed; inputs only move at posedge+1
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) tok_q.push_back({out_is_run, out_data});
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_tok(input string tag, input logic is_run, input logic [DATA_W-1:0] d);
        int n = 0;
        logic [DATA_W:0] t;
        while (tok_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (tok_q.size() == 0) begin
            check({tag, "_present"}, 64'(tok_q.size()), 64'd1);
        end else begin
            t = tok_q.pop_front();
            check(tag, 64'(t), 64'({is_run, d}));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_is_run", 64'(out_is_run), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_stat_in", 64'(stat_in), 64'd0);
        check("rst_stat_out", 64'(stat_out), 64'd0);
        tok_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: basic run
        do_reset();
        send(8'hAA); send(8'hAA); send(8'hAA); send(8'hBB);
        expect_tok("t1_lit_aa", 1'b0, 8'hAA);
        expect_tok("t1_run_2", 1'b1, 8'h02);
        expect_tok("t1_lit_bb", 1'b0, 8'hBB);
        settle();
        check("t1_stat_in", 64'(stat_in), 64'd4);
        check("t1_stat_out", 64'(stat_out), 64'd3);
        check("t1_no_extra", 64'(tok_q.size()), 64'd0);

        // 2: saturation at RUN_MAX = 15
        do_reset();
        for (int i = 0; i < 17; i++) send(8'h55);
        send(8'h66);
        expect_tok("t2_lit_55", 1'b0, 8'h55);
        expect_tok("t2_run_15", 1'b1, 8'h0F);
        expect_tok("t2_run_1", 1'b1, 8'h01);
        expect_tok("t2_lit_66", 1'b0, 8'h66);
        settle();
        check("t2_stat_in_wrap", 64'(stat_in), 64'd2);
        check("t2_stat_out", 64'(stat_out), 64'd4);

        // 3: flush closes the run and forgets the held sample
        do_reset();
        send(8'h11); send(8'h11); send(8'h11);
        flush = 1'b1;
        @(negedge clk);
        check("t3_flush_in_ready", 64'(in_ready), 64'd0);
        check("t3_flush_done_early", 64'(flush_done), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("t3_flush_done_pulse", 64'(flush_done), 64'd1);
        @(negedge clk);
        check("t3_flush_done_low", 64'(flush_done), 64'd0);
        @(posedge clk);
        #1;
        send(8'h11);
        expect_tok("t3_lit_11", 1'b0, 8'h11);
        expect_tok("t3_run_2", 1'b1, 8'h02);
        expect_tok("t3_lit_11_again", 1'b0, 8'h11);
        settle();
        check("t3_stat_out", 64'(stat_out), 64'd3);

        // 4: bypass mode
        do_reset();
        en_rle = 1'b0;
        send(8'h22); send(8'h22); send(8'h22);
        expect_tok("t4_lit_a", 1'b0, 8'h22);
        expect_tok("t4_lit_b", 1'b0, 8'h22);
        expect_tok("t4_lit_c", 1'b0, 8'h22);
        settle();
        check("t4_no_run", 64'(tok_q.size()), 64'd0);
        check("t4_stat_out", 64'(stat_out), 64'd3);
        en_rle = 1'b1;

        // 5: output backpressure
        do_reset();
        out_ready = 1'b0;
        send(8'h01);
        in_data  = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_in_ready_low", 64'(in_ready), 64'd0);
            check("t5_out_valid", 64'(out_valid), 64'd1);
            check("t5_out_data_held", 64'({out_is_run, out_data}), 64'({1'b0, 8'h01}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h01);
        send(8'h02);
        expect_tok("t5_lit_01", 1'b0, 8'h01);
        expect_tok("t5_run_1", 1'b1, 8'h01);
        expect_tok("t5_lit_02", 1'b0, 8'h02);
        settle();
        check("t5_stat_in", 64'(stat_in), 64'd3);
        check("t5_stat_out", 64'(stat_out), 64'd3);

        // 6a: reset with an open run of 3 discards it
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h33);
        expect_tok("t6_lit_33", 1'b0, 8'h33);
        do_reset();
        send(8'h33);
        send(8'h44);
        expect_tok("t6_post_lit_33", 1'b0, 8'h33);
        expect_tok("t6_post_lit_44", 1'b0, 8'h44);
        settle();
        check("t6_no_stale_run", 64'(tok_q.size()), 64'd0);
        check("t6_stat_out", 64'(stat_out), 64'd2);

        // 6b: reset with a token sitting in the buffer discards it
        out_ready = 1'b0;
        send(8'h77);
        @(negedge clk);
        check("t6_buffered", 64'(out_valid), 64'd1);
        do_reset();
        out_ready = 1'b1;
        settle();
        check("t6_buffer_dropped", 64'(tok_q.size()), 64'd0);
        check("t6_out_valid_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
